rvc_asap_lsu: RTL and testbench
===============================

Name: rvc_asap_lsu

Overview:
- Core-side load/store unit: the initiator that drives requests into the core's data memory.
- Takes one RV32I load/store per request and issues word-aligned, byte-enabled memory transactions over a valid/ready handshake.
- Splits misaligned accesses into two beats, merges read data and sign/zero-extends it, then returns one response to the core.
- Sits between the execute stage and the D_MEM port.

Parameters:
- MEM_RSP_TIMEOUT, 16: cycles WAITx may wait for MemRspValid before setting LsuRspErr.

Ports:
- Clock  in  1  core clock
- Rst  in  1  asynchronous, active-low reset
- LsuReqValid  in  1  core request valid
- LsuReqReady  out  1  unit can accept (IDLE)
- LsuReqWrEn  in  1  1=store, 0=load
- LsuReqFunct3  in  3  RV32I funct3: LB 000, LH 001, LW 010, LBU 100, LHU 101; stores use 000/001/010
- LsuReqAddr  in  32  byte address
- LsuReqWrData  in  32  store data, right-aligned
- LsuRspValid  out  1  one-cycle completion pulse
- LsuRspData  out  32  extended load data; 0 for stores/errors
- LsuRspErr  out  1  illegal funct3 or timeout
- MemReqValid  out  1  memory request valid
- MemReqReady  in  1  memory accepts request
- MemReqWrEn  out  1  write beat
- MemReqAddr  out  32  word-aligned address, [1:0]=0
- MemReqByteEn  out  4  lane enables
- MemReqWrData  out  32  lane-positioned write data
- MemRspValid  in  1  read data valid, at least 1 cycle after acceptance
- MemRspData  in  32  read word

Behaviour:
- Reset: async on Rst=0. State=IDLE; all outputs 0 except LsuReqReady=1. Any in-flight beat is dropped.
- Accept: a request is accepted when LsuReqValid&&LsuReqReady. Operands are captured in registers at acceptance.
- Byte lanes:
  - size = 1/2/4 bytes from funct3[1:0]; off = addr[1:0].
  - 8-bit mask = ((1<<size)-1) << off.
  - Beat0 uses mask[3:0] at {addr[31:2],2'b00}.
  - Beat1 exists only if mask[7:4]!=0; it uses mask[7:4] at beat0 address+4, mod 2^32 (0xFFFFFFFC wraps to 0x00000000).
- Write data: {32'b0,WrData} << (8*off); low word goes to beat0, high word to beat1.
- Illegal funct3 (011,110,111; stores also 1xx):
  - no memory traffic;
  - state goes to RESP with LsuRspErr=1.
- FSM:
  - IDLE -> REQ0 on accept (or -> RESP on illegal funct3).
  - REQ0: MemReqValid=1, fields stable until MemReqReady. On acceptance:
    - load -> WAIT0;
    - store -> REQ1 if two beats, else RESP.
  - WAIT0: on MemRspValid, capture lo word -> REQ1 if two beats, else RESP.
  - REQ1 / WAIT1: same rules as REQ0 / WAIT0 for the high word.
  - RESP: LsuRspValid=1 for exactly one cycle -> IDLE. LsuReqReady stays 0 outside IDLE.
- Load merge: ({hi,lo} >> 8*off), truncated to size. Sign-extended for LB/LH, zero-extended for LBU/LHU. hi=0 for single-beat loads.
- Timeout: a WAIT state that exceeds MEM_RSP_TIMEOUT cycles goes to RESP with LsuRspErr=1 and LsuRspData=0. The late response is ignored.
- MemRspValid outside WAIT states is ignored.
- Latency, aligned load, MemReqReady=1, memory answers 1 cycle after acceptance: accept at N, MemReqValid at N+1, MemRspValid at N+2, LsuRspValid at N+3.
- Latency, aligned store: LsuRspValid at N+2.
- Each extra beat adds 2 cycles (load) or 1 cycle (store).
- Stores complete on beat acceptance; the memory returns no response for writes.

Decomposition:
- rvc_asap_pkg holds:
  - t_lsu_state enum (IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP);
  - funct3 constants LSU_B/H/W/BU/HU;
  - t_lsu_req struct {WrEn, Funct3, Addr, WrData}.
- Sub-module rvc_asap_lsu_align is purely combinational. Input: addr offset, size, wr data, captured {hi,lo}, funct3. Output: 8-bit mask, 64-bit shifted write data, extended load data.
- The FSM, counters and capture registers stay in rvc_asap_lsu.

Test Plan:
- LW addr 0x100, MemRspData 0xDEADBEEF -> one beat (ByteEn 1111, MemReqAddr 0x100); LsuRspData 0xDEADBEEF; LsuRspValid at N+3.
- LB 0x103 with word 0x80000000 -> ByteEn 1000, LsuRspData 0xFFFFFF80. LBU at the same address -> 0x00000080.
- SW 0x106, data 0xAABBCCDD -> beat0: 0x104, ByteEn 1100, WrData 0xCCDD0000; beat1: 0x108, ByteEn 0011, WrData 0x0000AABB. LsuRspValid once.
- LH 0xFFFFFFFF, lo word 0x7F000000, hi word 0x000000FF -> beat1 address 0x00000000; LsuRspData 0xFFFFFF7F.
- MemReqReady held 0 for 5 cycles, then funct3=011 -> the held request's fields stay stable throughout. The illegal request produces no MemReqValid and gets LsuRspErr=1 within 2 cycles.
- Rst asserted in WAIT0 -> MemReqValid=0 and LsuReqReady=1 immediately. A later MemRspValid produces no LsuRspValid. A timeout with no response gives LsuRspErr=1 after 16 cycles.

Source files
------------

// File: rtl/rvc_asap_pkg.sv
// rtl/rvc_asap_pkg.sv - shared types and constants for the rvc_asap load/store unit
package rvc_asap_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    WAIT0 = 3'd2,
    REQ1  = 3'd3,
    WAIT1 = 3'd4,
    RESP  = 3'd5
  } t_lsu_state;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef struct packed {
    logic        wr_en;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wr_data;
  } t_lsu_req;

  // Stores only come in signed-width encodings; unsigned variants are load-only.
  function automatic logic lsu_illegal(input logic wr_en, input logic [2:0] funct3);
    logic legal;
    legal = (funct3 == LSU_B) || (funct3 == LSU_H) || (funct3 == LSU_W) ||
            (!wr_en && ((funct3 == LSU_BU) || (funct3 == LSU_HU)));
    return !legal;
  endfunction

endpackage

// File: rtl/rvc_asap_lsu_align.sv
// rtl/rvc_asap_lsu_align.sv - byte-lane mask, store data shift and load merge/extend
module rvc_asap_lsu_align
  import rvc_asap_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic [31:0] wr_data,
  input  logic [31:0] rd_hi,
  input  logic [31:0] rd_lo,
  input  logic [2:0]  funct3,
  output logic [7:0]  mask,
  output logic [63:0] wr_shifted,
  output logic [31:0] rd_ext
);

  logic [7:0]  base_mask;
  logic [63:0] rd_shifted;

  always_comb begin
    case (size)
      2'b00:   base_mask = 8'b0000_0001;
      2'b01:   base_mask = 8'b0000_0011;
      2'b10:   base_mask = 8'b0000_1111;
      default: base_mask = 8'b0000_0000;
    endcase
  end

  assign mask       = base_mask << off;
  assign wr_shifted = {32'b0, wr_data} << {off, 3'b000};
  assign rd_shifted = {rd_hi, rd_lo} >> {off, 3'b000};

  always_comb begin
    case (funct3)
      LSU_B:   rd_ext = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      LSU_H:   rd_ext = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      LSU_W:   rd_ext = rd_shifted[31:0];
      LSU_BU:  rd_ext = {24'b0, rd_shifted[7:0]};
      LSU_HU:  rd_ext = {16'b0, rd_shifted[15:0]};
      default: rd_ext = 32'b0;
    endcase
  end

endmodule

// File: rtl/rvc_asap_lsu.sv
// rtl/rvc_asap_lsu.sv - RV32I load/store unit issuing word-aligned byte-enabled memory beats
module rvc_asap_lsu
  import rvc_asap_pkg::*;
#(
  parameter int MEM_RSP_TIMEOUT = 16
) (
  input  logic        Clock,
  input  logic        Rst,
  input  logic        LsuReqValid,
  output logic        LsuReqReady,
  input  logic        LsuReqWrEn,
  input  logic [2:0]  LsuReqFunct3,
  input  logic [31:0] LsuReqAddr,
  input  logic [31:0] LsuReqWrData,
  output logic        LsuRspValid,
  output logic [31:0] LsuRspData,
  output logic        LsuRspErr,
  output logic        MemReqValid,
  input  logic        MemReqReady,
  output logic        MemReqWrEn,
  output logic [31:0] MemReqAddr,
  output logic [3:0]  MemReqByteEn,
  output logic [31:0] MemReqWrData,
  input  logic        MemRspValid,
  input  logic [31:0] MemRspData
);

  localparam int CW = $clog2(MEM_RSP_TIMEOUT + 1);

  t_lsu_state     state, state_nxt;
  t_lsu_req       req;
  logic           err;
  logic [31:0]    rd_lo, rd_hi;
  logic [CW-1:0]  wait_cnt;
  logic           accept, illegal, two_beats, in_wait, timeout;
  logic [7:0]     mask;
  logic [63:0]    wr_shifted;
  logic [31:0]    rd_ext, base_addr;

  assign accept    = LsuReqValid && (state == IDLE);
  assign illegal   = lsu_illegal(LsuReqWrEn, LsuReqFunct3);
  assign two_beats = |mask[7:4];
  assign base_addr = {req.addr[31:2], 2'b00};
  assign in_wait   = (state == WAIT0) || (state == WAIT1);
  assign timeout   = in_wait && !MemRspValid && (wait_cnt == CW'(MEM_RSP_TIMEOUT - 1));

  rvc_asap_lsu_align u_align (
    .off        (req.addr[1:0]),
    .size       (req.funct3[1:0]),
    .wr_data    (req.wr_data),
    .rd_hi      (rd_hi),
    .rd_lo      (rd_lo),
    .funct3     (req.funct3),
    .mask       (mask),
    .wr_shifted (wr_shifted),
    .rd_ext     (rd_ext)
  );

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = illegal ? RESP : REQ0;
      REQ0:  if (MemReqReady) state_nxt = !req.wr_en ? WAIT0 : (two_beats ? REQ1 : RESP);
      WAIT0: if (MemRspValid) state_nxt = two_beats ? REQ1 : RESP;
             else if (timeout) state_nxt = RESP;
      REQ1:  if (MemReqReady) state_nxt = req.wr_en ? RESP : WAIT1;
      WAIT1: if (MemRspValid || timeout) state_nxt = RESP;
      RESP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // hi is cleared at accept so single-beat loads merge against zero.
  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      req      <= '0;
      err      <= 1'b0;
      rd_lo    <= 32'b0;
      rd_hi    <= 32'b0;
      wait_cnt <= '0;
    end else begin
      if (accept) begin
        req   <= '{wr_en: LsuReqWrEn, funct3: LsuReqFunct3, addr: LsuReqAddr, wr_data: LsuReqWrData};
        err   <= illegal;
        rd_lo <= 32'b0;
        rd_hi <= 32'b0;
      end
      if (state == WAIT0 && MemRspValid) rd_lo <= MemRspData;
      if (state == WAIT1 && MemRspValid) rd_hi <= MemRspData;
      if (timeout) err <= 1'b1;
      if (in_wait && state_nxt == state) wait_cnt <= wait_cnt + 1'b1;
      else                               wait_cnt <= '0;
    end
  end

  always_comb begin
    LsuReqReady  = (state == IDLE);
    LsuRspValid  = 1'b0;
    LsuRspErr    = 1'b0;
    LsuRspData   = 32'b0;
    MemReqValid  = 1'b0;
    MemReqWrEn   = 1'b0;
    MemReqAddr   = 32'b0;
    MemReqByteEn = 4'b0;
    MemReqWrData = 32'b0;
    case (state)
      REQ0: begin
        MemReqValid  = 1'b1;
        MemReqWrEn   = req.wr_en;
        MemReqAddr   = base_addr;
        MemReqByteEn = mask[3:0];
        MemReqWrData = wr_shifted[31:0];
      end
      REQ1: begin
        MemReqValid  = 1'b1;
        MemReqWrEn   = req.wr_en;
        MemReqAddr   = base_addr + 32'd4;
        MemReqByteEn = mask[7:4];
        MemReqWrData = wr_shifted[63:32];
      end
      RESP: begin
        LsuRspValid = 1'b1;
        LsuRspErr   = err;
        LsuRspData  = (err || req.wr_en) ? 32'b0 : rd_ext;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rvc_asap_lsu.sv
// tb/tb_rvc_asap_lsu.sv - directed self-checking bench for rvc_asap_lsu
module tb_rvc_asap_lsu;

  logic        Clock = 1'b0;
  logic        Rst = 1'b0;
  logic        LsuReqValid = 1'b0;
  logic        LsuReqReady;
  logic        LsuReqWrEn = 1'b0;
  logic [2:0]  LsuReqFunct3 = 3'b0;
  logic [31:0] LsuReqAddr = 32'b0;
  logic [31:0] LsuReqWrData = 32'b0;
  logic        LsuRspValid;
  logic [31:0] LsuRspData;
  logic        LsuRspErr;
  logic        MemReqValid;
  logic        MemReqReady = 1'b0;
  logic        MemReqWrEn;
  logic [31:0] MemReqAddr;
  logic [3:0]  MemReqByteEn;
  logic [31:0] MemReqWrData;
  logic        MemRspValid = 1'b0;
  logic [31:0] MemRspData = 32'b0;

  rvc_asap_lsu #(.MEM_RSP_TIMEOUT(16)) dut (
    .Clock(Clock), .Rst(Rst),
    .LsuReqValid(LsuReqValid), .LsuReqReady(LsuReqReady), .LsuReqWrEn(LsuReqWrEn),
    .LsuReqFunct3(LsuReqFunct3), .LsuReqAddr(LsuReqAddr), .LsuReqWrData(LsuReqWrData),
    .LsuRspValid(LsuRspValid), .LsuRspData(LsuRspData), .LsuRspErr(LsuRspErr),
    .MemReqValid(MemReqValid), .MemReqReady(MemReqReady), .MemReqWrEn(MemReqWrEn),
    .MemReqAddr(MemReqAddr), .MemReqByteEn(MemReqByteEn), .MemReqWrData(MemReqWrData),
    .MemRspValid(MemRspValid), .MemRspData(MemRspData)
  );

  always #5 Clock = ~Clock;

  int errors = 0;
  int checks = 0;

  int          nbeats, mem_seen, rsp_cnt, rsp_cycle;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] beat_addr [2];
  logic [3:0]  beat_be   [2];
  logic [31:0] beat_wd   [2];
  logic        beat_we   [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction with an always-ready memory answering loads one cycle after acceptance.
  // Cycle 0 is the accept cycle; outputs are sampled at each falling edge.
  task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] lo, input logic [31:0] hi,
                     input logic no_rsp);
    int rsp_due;
    int rsp_beat;
    rsp_due = -1; rsp_beat = 0;
    nbeats = 0; mem_seen = 0; rsp_cnt = 0; rsp_cycle = -1; rsp_data = 32'hx; rsp_err = 1'bx;
    for (int c = 0; c < 24; c++) begin
      @(negedge Clock);
      LsuReqValid  = (c == 0);
      LsuReqWrEn   = we;
      LsuReqFunct3 = f3;
      LsuReqAddr   = addr;
      LsuReqWrData = wd;
      MemReqReady  = 1'b1;
      MemRspValid  = (rsp_due == c);
      MemRspData   = MemRspValid ? ((rsp_beat == 0) ? lo : hi) : 32'h0;
      if (MemReqValid) begin
        mem_seen++;
        if (nbeats < 2) begin
          beat_addr[nbeats] = MemReqAddr;
          beat_be[nbeats]   = MemReqByteEn;
          beat_wd[nbeats]   = MemReqWrData;
          beat_we[nbeats]   = MemReqWrEn;
        end
        if (!MemReqWrEn && !no_rsp) begin
          rsp_due  = c + 1;
          rsp_beat = nbeats;
        end
        nbeats++;
      end
      if (LsuRspValid) begin
        rsp_cnt++;
        if (rsp_cycle < 0) begin
          rsp_cycle = c;
          rsp_data  = LsuRspData;
          rsp_err   = LsuRspErr;
        end
      end
    end
    @(negedge Clock);
    MemRspValid = 1'b0;
  endtask

  int late_rsp;

  initial begin
    MemReqReady = 1'b0;
    repeat (2) @(negedge Clock);
    chk("rst_ready", {31'b0, LsuReqReady}, 32'd1);
    chk("rst_memvalid", {31'b0, MemReqValid}, 32'd0);
    chk("rst_rspvalid", {31'b0, LsuRspValid}, 32'd0);
    chk("rst_memaddr", MemReqAddr, 32'd0);
    Rst = 1'b1;

    // LW aligned
    run(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0);
    chk("lw_beats", nbeats, 32'd1);
    chk("lw_addr", beat_addr[0], 32'h100);
    chk("lw_be", {28'b0, beat_be[0]}, 32'hF);
    chk("lw_data", rsp_data, 32'hDEADBEEF);
    chk("lw_lat", rsp_cycle, 32'd3);
    chk("lw_cnt", rsp_cnt, 32'd1);
    chk("lw_err", {31'b0, rsp_err}, 32'd0);

    // LB / LBU upper lane
    run(1'b0, 3'b000, 32'h103, 32'h0, 32'h80000000, 32'h0, 1'b0);
    chk("lb_be", {28'b0, beat_be[0]}, 32'h8);
    chk("lb_addr", beat_addr[0], 32'h100);
    chk("lb_data", rsp_data, 32'hFFFFFF80);
    run(1'b0, 3'b100, 32'h103, 32'h0, 32'h80000000, 32'h0, 1'b0);
    chk("lbu_data", rsp_data, 32'h00000080);

    // SW misaligned, two beats
    run(1'b1, 3'b010, 32'h106, 32'hAABBCCDD, 32'h0, 32'h0, 1'b0);
    chk("sw_beats", nbeats, 32'd2);
    chk("sw_a0", beat_addr[0], 32'h104);
    chk("sw_be0", {28'b0, beat_be[0]}, 32'hC);
    chk("sw_wd0", beat_wd[0], 32'hCCDD0000);
    chk("sw_we0", {31'b0, beat_we[0]}, 32'd1);
    chk("sw_a1", beat_addr[1], 32'h108);
    chk("sw_be1", {28'b0, beat_be[1]}, 32'h3);
    chk("sw_wd1", beat_wd[1], 32'h0000AABB);
    chk("sw_cnt", rsp_cnt, 32'd1);
    chk("sw_lat", rsp_cycle, 32'd3);
    chk("sw_data", rsp_data, 32'h0);

    // LH wrapping across the top of the address space
    run(1'b0, 3'b001, 32'hFFFFFFFF, 32'h0, 32'h7F000000, 32'h000000FF, 1'b0);
    chk("lh_beats", nbeats, 32'd2);
    chk("lh_a0", beat_addr[0], 32'hFFFFFFFC);
    chk("lh_be0", {28'b0, beat_be[0]}, 32'h8);
    chk("lh_a1", beat_addr[1], 32'h0);
    chk("lh_be1", {28'b0, beat_be[1]}, 32'h1);
    chk("lh_data", rsp_data, 32'hFFFFFF7F);
    chk("lh_lat", rsp_cycle, 32'd5);

    // SB held by MemReqReady=0 for 5 cycles
    @(negedge Clock);
    MemReqReady  = 1'b0;
    LsuReqValid  = 1'b1;
    LsuReqWrEn   = 1'b1;
    LsuReqFunct3 = 3'b000;
    LsuReqAddr   = 32'h201;
    LsuReqWrData = 32'h12345612;
    for (int c = 1; c <= 5; c++) begin
      @(negedge Clock);
      LsuReqValid  = 1'b0;
      LsuReqAddr   = 32'hFFFF0000;
      LsuReqWrData = 32'h0;
      chk("hold_valid", {31'b0, MemReqValid}, 32'd1);
      chk("hold_addr", MemReqAddr, 32'h200);
      chk("hold_be", {28'b0, MemReqByteEn}, 32'h2);
      chk("hold_wd", MemReqWrData, 32'h34561200);
      chk("hold_ready", {31'b0, LsuReqReady}, 32'd0);
    end
    MemReqReady = 1'b1;
    @(negedge Clock);
    chk("hold_rsp", {31'b0, LsuRspValid}, 32'd1);
    chk("hold_rsperr", {31'b0, LsuRspErr}, 32'd0);

    // Illegal funct3 values
    run(1'b0, 3'b011, 32'h300, 32'h0, 32'h0, 32'h0, 1'b0);
    chk("ill_mem", mem_seen, 32'd0);
    chk("ill_err", {31'b0, rsp_err}, 32'd1);
    chk("ill_lat", rsp_cycle, 32'd1);
    chk("ill_data", rsp_data, 32'h0);
    run(1'b1, 3'b100, 32'h300, 32'h0, 32'h0, 32'h0, 1'b0);
    chk("ills_mem", mem_seen, 32'd0);
    chk("ills_err", {31'b0, rsp_err}, 32'd1);

    // Reset while in WAIT0
    @(negedge Clock);
    LsuReqValid  = 1'b1;
    LsuReqWrEn   = 1'b0;
    LsuReqFunct3 = 3'b010;
    LsuReqAddr   = 32'h400;
    MemReqReady  = 1'b1;
    @(negedge Clock);
    LsuReqValid = 1'b0;
    chk("rstw_req0", {31'b0, MemReqValid}, 32'd1);
    @(negedge Clock);
    chk("rstw_inwait", {31'b0, LsuReqReady}, 32'd0);
    Rst = 1'b0;
    #1;
    chk("rstw_ready", {31'b0, LsuReqReady}, 32'd1);
    chk("rstw_memvalid", {31'b0, MemReqValid}, 32'd0);
    @(negedge Clock);
    Rst = 1'b1;
    MemRspValid = 1'b1;
    MemRspData  = 32'h12345678;
    late_rsp = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge Clock);
      MemRspValid = 1'b0;
      if (LsuRspValid) late_rsp++;
    end
    chk("rstw_norsp", late_rsp, 32'd0);

    // Timeout with no memory response
    run(1'b0, 3'b010, 32'h500, 32'h0, 32'h0, 32'h0, 1'b1);
    chk("to_beats", nbeats, 32'd1);
    chk("to_err", {31'b0, rsp_err}, 32'd1);
    chk("to_data", rsp_data, 32'h0);
    chk("to_lat", rsp_cycle, 32'd18);
    chk("to_cnt", rsp_cnt, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
